// File: rtl/jtshouse_obj_dma.sv
// jtshouse_obj_dma -- object-table DMA sequencer.
//
// A write to the object MMR block (dma_on pulse) arms a copy. At the next
// vertical-blank start the block requests the object RAM bus. Once the bus is
// granted, it streams all 2^AW bytes of the object table into the shadow RAM
// that the sprite engine scans. It then releases the bus and pulses done.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   dma_on      one-cycle copy request from the object MMR block
//   lvbl        vertical blank, active low
//   bus_req     object RAM bus request to the CPU arbiter
//   bus_ack     bus grant; may drop on any cycle, which pauses the copy
//   src_addr    object RAM read address (RAM has 1-cycle read latency)
//   src_dout    object RAM read data
//   dst_addr    shadow RAM write address
//   dst_din     shadow RAM write data
//   dst_we      shadow RAM write strobe
//   busy        high from leaving IDLE until returning to IDLE
//   done        one-cycle pulse at the end of a transfer
module jtshouse_obj_dma #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dma_on,
  input  logic          lvbl,
  output logic          bus_req,
  input  logic          bus_ack,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_dout,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_din,
  output logic          dst_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COPY,
    FLUSH
  } state_t;

  // Read counter carries one extra bit so it never wraps back to zero.
  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  state_t      state;
  logic        pending;
  logic        lvbl_l;
  logic        vbl_start;
  logic [AW:0] rcnt;

  assign vbl_start = lvbl_l & ~lvbl;
  assign src_addr  = rcnt[AW-1:0];
  // Read data lands one cycle after the address. The write is delayed by the
  // same cycle, so the RAM output feeds the shadow write port directly.
  assign dst_din   = src_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= 1'b0;
      lvbl_l   <= 1'b1;
      rcnt     <= '0;
      bus_req  <= 1'b0;
      dst_we   <= 1'b0;
      dst_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      lvbl_l <= lvbl;
      done   <= 1'b0;
      if (dma_on) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (pending && vbl_start) begin
            // A request arriving on the start cycle is kept for the next frame.
            pending <= dma_on;
            rcnt    <= '0;
            bus_req <= 1'b1;
            busy    <= 1'b1;
            state   <= REQ;
          end
        end

        REQ: begin
          if (bus_ack) state <= COPY;
        end

        COPY: begin
          if (bus_ack) begin
            dst_we   <= 1'b1;
            dst_addr <= rcnt[AW-1:0];
            rcnt     <= rcnt + ONE;
            if (rcnt == LAST) begin
              bus_req <= 1'b0;
              state   <= FLUSH;
            end
          end else begin
            // Grant lost: hold the address and let any owed write drain.
            dst_we <= 1'b0;
          end
        end

        FLUSH: begin
          dst_we <= 1'b0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtshouse_obj_dma.sv
// Testbench for jtshouse_obj_dma. Two instances are used: AW=11 (full object
// table) and AW=4 (short transfers). A select line routes the shared stimulus
// to one instance at a time and keeps the other idle.
module tb_jtshouse_obj_dma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, dma_on, lvbl, bus_ack, sel;

  // AW=11 instance
  logic        dma_on_a, lvbl_a, bus_ack_a, bus_req_a, dst_we_a, busy_a, done_a;
  logic [10:0] src_addr_a, dst_addr_a;
  logic [7:0]  src_dout_a, dst_din_a;
  // AW=4 instance
  logic        dma_on_b, lvbl_b, bus_ack_b, bus_req_b, dst_we_b, busy_b, done_b;
  logic [3:0]  src_addr_b, dst_addr_b;
  logic [7:0]  src_dout_b, dst_din_b;

  assign dma_on_a  = dma_on & ~sel;
  assign lvbl_a    = lvbl | sel;
  assign bus_ack_a = bus_ack & ~sel;
  assign dma_on_b  = dma_on & sel;
  assign lvbl_b    = lvbl | ~sel;
  assign bus_ack_b = bus_ack & sel;

  jtshouse_obj_dma #(.AW(11), .DW(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .dma_on(dma_on_a), .lvbl(lvbl_a),
    .bus_req(bus_req_a), .bus_ack(bus_ack_a), .src_addr(src_addr_a),
    .src_dout(src_dout_a), .dst_addr(dst_addr_a), .dst_din(dst_din_a),
    .dst_we(dst_we_a), .busy(busy_a), .done(done_a)
  );

  jtshouse_obj_dma #(.AW(4), .DW(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .dma_on(dma_on_b), .lvbl(lvbl_b),
    .bus_req(bus_req_b), .bus_ack(bus_ack_b), .src_addr(src_addr_b),
    .src_dout(src_dout_b), .dst_addr(dst_addr_b), .dst_din(dst_din_b),
    .dst_we(dst_we_b), .busy(busy_b), .done(done_b)
  );

  // Selected-instance view
  logic        bus_req_s, dst_we_s, busy_s, done_s;
  logic [10:0] dst_addr_s;
  logic [7:0]  dst_din_s;
  assign bus_req_s  = sel ? bus_req_b : bus_req_a;
  assign dst_we_s   = sel ? dst_we_b  : dst_we_a;
  assign busy_s     = sel ? busy_b    : busy_a;
  assign done_s     = sel ? done_b    : done_a;
  assign dst_addr_s = sel ? {7'd0, dst_addr_b} : dst_addr_a;
  assign dst_din_s  = sel ? dst_din_b : dst_din_a;

  // Object RAM (1-cycle read latency) and shadow RAM image
  logic [7:0] mem    [0:2047];
  logic [7:0] shadow [0:2047];
  always @(posedge clk) begin
    src_dout_a <= mem[src_addr_a];
    src_dout_b <= mem[{7'd0, src_addr_b}];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-transfer measurements
  int cyc = 0;
  int m_writes, m_done, m_breq, m_busy, m_order, m_bad, exp_addr, t_ack, t_done;

  task automatic clear_meas();
    m_writes = 0; m_done = 0; m_breq = 0; m_busy = 0; m_order = 0;
    exp_addr = 0; t_ack = -1; t_done = -1;
  endtask

  // Advance one clock and sample 1 time unit after the edge. A write strobe
  // seen here commits at the next edge with the data shown now.
  task automatic sample_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (dst_we_s) begin
      shadow[dst_addr_s] = dst_din_s;
      if (int'(dst_addr_s) != exp_addr) m_order++;
      exp_addr++;
      m_writes++;
    end
    if (done_s) begin
      m_done++;
      t_done = cyc;
    end
    if (bus_req_s) m_breq++;
    if (busy_s)    m_busy++;
  endtask

  typedef struct {
    bit sel;        // 0: AW=11 instance, 1: AW=4 instance
    bit arm;        // dma_on pulse before the vblank edge
    int ack_delay;  // grant after bus_req seen this many cycles
    int gap_at;     // drop grant after this address is read (-1: never)
    int gap_len;    // grant-low cycles
    int rise_at;    // lvbl returns high this many cycles after copy start (0: never)
    bit mid_dma;    // dma_on pulse 4 cycles into the transfer
    int budget;
    int exp_writes, exp_done, exp_breq, exp_busy, exp_lat, exp_bad;
  } vec_t;

  // Runs one vblank. In random mode bus_ack is random each cycle. The expected
  // timing follows from the grant count: one granted cycle wins the bus, then
  // one granted cycle per byte. bus_req covers the cycles up to the last
  // granted read, and done follows two cycles later.
  task automatic run_xfer(input vec_t v, input bit rnd, input bit exp_copy,
                          output int c0, output int c_last);
    int n, seen_req, gap_left, post, acks;
    bit gapped;
    n = v.sel ? 16 : 2048;
    seen_req = 0; gap_left = 0; post = 0; acks = 0; gapped = 0; c_last = -1;
    sel = v.sel; lvbl = 1'b1; bus_ack = 1'b0; dma_on = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem[i]    = 8'($urandom);
      shadow[i] = ~mem[i];
    end
    repeat (3) sample_cycle();
    clear_meas();
    if (v.arm) begin
      dma_on = 1'b1;
      sample_cycle();
      dma_on = 1'b0;
    end
    lvbl = 1'b0;
    sample_cycle();
    c0 = cyc;
    for (int k = 0; k < v.budget; k++) begin
      if (rnd) begin
        bus_ack = ($urandom_range(3) != 0);
        if (exp_copy && c_last < 0 && bus_ack) begin
          acks++;
          if (acks == n + 1) c_last = cyc;
        end
      end else begin
        if (bus_req_s) seen_req++;
        if (t_ack < 0 && seen_req >= v.ack_delay) begin
          bus_ack = 1'b1;
          t_ack   = cyc;
        end else if (gap_left > 0) begin
          gap_left--;
          if (gap_left == 0) bus_ack = 1'b1;
        end else if (!gapped && v.gap_at >= 0 && dst_we_s && int'(dst_addr_s) == v.gap_at) begin
          gapped   = 1'b1;
          gap_left = v.gap_len;
          bus_ack  = 1'b0;
        end
      end
      dma_on = v.mid_dma && (cyc - c0 == 4);
      if (v.rise_at > 0 && cyc - c0 == v.rise_at) lvbl = 1'b1;
      sample_cycle();
      if (m_done > 0) begin
        post++;
        if (post > 3) break;
      end
    end
    bus_ack = 1'b0; dma_on = 1'b0; lvbl = 1'b1;
    sample_cycle();
    m_bad = 0;
    for (int i = 0; i < n; i++)
      if (shadow[i] !== mem[i]) m_bad++;
  endtask

  vec_t vecs[8];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c_last, lat, pend_m, reached;
    vec_t r;

    //            sel arm dly gap    len rise mid budget writes done breq busy lat   bad
    vecs[0] = '{0, 1, 3, -1,    0, 0, 0, 2300, 2048, 1, 2051, 2052, 2050, 0};    // basic full copy
    vecs[1] = '{0, 0, 3, -1,    0, 0, 0, 40,   0,    0, 0,    0,    0,    2048}; // vblank, no request
    vecs[2] = '{0, 1, 3, 'h100, 5, 0, 0, 2300, 2048, 1, 2056, 2057, 2055, 0};    // grant gap after 0x100
    vecs[3] = '{1, 1, 1, -1,    0, 6, 0, 60,   16,   1, 17,   18,   18,   0};    // lvbl rises mid-copy
    vecs[4] = '{1, 1, 2, -1,    0, 0, 1, 60,   16,   1, 18,   19,   18,   0};    // re-arm during copy
    vecs[5] = '{1, 0, 1, -1,    0, 0, 0, 60,   16,   1, 17,   18,   18,   0};    // re-armed copy runs
    vecs[6] = '{1, 0, 1, -1,    0, 0, 0, 40,   0,    0, 0,    0,    0,    16};   // nothing further
    vecs[7] = '{1, 1, 4, 0,     2, 0, 0, 60,   16,   1, 22,   23,   20,   0};    // gap after first byte

    sel = 1'b0; dma_on = 1'b0; lvbl = 1'b1; bus_ack = 1'b0;
    rst_n = 1'b0;
    #12;
    check("reset bus_req",  32'(bus_req_a),  0);
    check("reset dst_we",   32'(dst_we_a),   0);
    check("reset busy",     32'(busy_a),     0);
    check("reset done",     32'(done_a),     0);
    check("reset src_addr", 32'(src_addr_a), 0);
    check("reset dst_addr", 32'(dst_addr_a), 0);
    check("reset bus_req4", 32'(bus_req_b),  0);
    check("reset busy4",    32'(busy_b),     0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_xfer(vecs[i], 1'b0, 1'b0, c0, c_last);
      lat = (m_done > 0) ? t_done - t_ack : 0;
      check($sformatf("vec%0d writes", i),  m_writes, vecs[i].exp_writes);
      check($sformatf("vec%0d done", i),    m_done,   vecs[i].exp_done);
      check($sformatf("vec%0d bus_req", i), m_breq,   vecs[i].exp_breq);
      check($sformatf("vec%0d busy", i),    m_busy,   vecs[i].exp_busy);
      check($sformatf("vec%0d latency", i), lat,      vecs[i].exp_lat);
      check($sformatf("vec%0d shadow", i),  m_bad,    vecs[i].exp_bad);
      check($sformatf("vec%0d order", i),   m_order,  0);
    end

    // Reset in the middle of a copy, with a re-arm already pending
    sel = 1'b0; lvbl = 1'b1; bus_ack = 1'b0;
    repeat (3) sample_cycle();
    dma_on = 1'b1;
    sample_cycle();
    dma_on = 1'b0;
    lvbl = 1'b0;
    sample_cycle();
    bus_ack = 1'b1;
    reached = 0;
    for (int k = 0; k < 1000; k++) begin
      dma_on = (k == 10);
      sample_cycle();
      if (dst_we_s && dst_addr_s == 11'h1FF) begin
        reached = 1;
        break;
      end
    end
    dma_on = 1'b0;
    check("rst_mid reached 0x1FF", reached, 1);
    check("rst_mid bus_req before", 32'(bus_req_a), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid bus_req", 32'(bus_req_a), 0);
    check("rst_mid dst_we",  32'(dst_we_a),  0);
    check("rst_mid busy",    32'(busy_a),    0);
    bus_ack = 1'b0; lvbl = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) sample_cycle();
    clear_meas();
    lvbl = 1'b0;
    repeat (20) sample_cycle();
    lvbl = 1'b1;
    check("rst_mid no copy bus_req", m_breq,   0);
    check("rst_mid no copy writes",  m_writes, 0);

    // Randomised frames on the AW=4 instance
    pend_m = 0;
    for (int t = 0; t < 30; t++) begin
      bit exp_copy;
      int exp_breq, exp_off, off;
      r = '{1, 1'($urandom_range(1)), 1, -1, 0, 0, ($urandom_range(2) == 0), 200,
            0, 0, 0, 0, 0, 0};
      r.rise_at = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(10, 2));
      exp_copy = r.arm || (pend_m != 0);
      run_xfer(r, 1'b1, exp_copy, c0, c_last);
      pend_m = r.mid_dma ? 1 : 0;
      exp_breq = exp_copy ? ((c_last >= 0) ? c_last - c0 + 1 : -2) : 0;
      exp_off  = exp_copy ? ((c_last >= 0) ? c_last - c0 + 2 : -2) : -1;
      off      = (m_done > 0) ? t_done - c0 : -1;
      check($sformatf("rnd%0d writes", t),  m_writes, exp_copy ? 16 : 0);
      check($sformatf("rnd%0d done", t),    m_done,   exp_copy ? 1 : 0);
      check($sformatf("rnd%0d bus_req", t), m_breq,   exp_breq);
      check($sformatf("rnd%0d busy", t),    m_busy,   exp_copy ? exp_breq + 1 : 0);
      check($sformatf("rnd%0d done_at", t), off,      exp_off);
      check($sformatf("rnd%0d shadow", t),  m_bad,    exp_copy ? 0 : 16);
      check($sformatf("rnd%0d order", t),   m_order,  0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
